// File: rtl/storeunit.sv
// Store data-path and single-beat bus master for sb/sh/sw/swl/swr.
// swl/swr lane mapping is built only when STORE_UNALIGNED_EN is defined.
module storeunit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] storedata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest
);

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SWR = 6'b101110;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE,
        FAULT
    } state_t;

    state_t      state;
    logic [1:0]  off;
    logic        ok;
    logic [3:0]  be;
    logic [31:0] wd;

    assign off = addr[1:0];

    always_comb begin
        ok = 1'b0;
        be = '0;
        wd = '0;
        unique case (1'b1)
            (opcode == OP_SB): begin
                ok = 1'b1;
                be = 4'b0001 << off;
                wd = {24'b0, storedata[7:0]} << {off, 3'b000};
            end
            (opcode == OP_SH): begin
                ok = ~off[0];
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = off[1] ? {storedata[15:0], 16'b0}
                            : {16'b0, storedata[15:0]};
            end
            (opcode == OP_SW): begin
                ok = (off == 2'b00);
                be = 4'b1111;
                wd = storedata;
            end
`ifdef STORE_UNALIGNED_EN
            // swl fills lanes 0..off from the top of rt; swr fills off..3 from the bottom
            (opcode == OP_SWL): begin
                ok = 1'b1;
                be = 4'b1111 >> (~off);
                wd = storedata >> {~off, 3'b000};
            end
            (opcode == OP_SWR): begin
                ok = 1'b1;
                be = 4'b1111 << off;
                wd = storedata << {off, 3'b000};
            end
`else
            (opcode == OP_SWL), (opcode == OP_SWR): begin
                ok = 1'b0;
            end
`endif
            default: begin
                ok = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ok) begin
                            state          <= WRITE;
                            busy           <= 1'b1;
                            mem_write      <= 1'b1;
                            mem_address    <= {addr[31:2], 2'b00};
                            mem_byteenable <= be;
                            mem_writedata  <= wd;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!mem_waitrequest) begin
                        state          <= DONE;
                        done           <= 1'b1;
                        busy           <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_address    <= '0;
                        mem_byteenable <= '0;
                        mem_writedata  <= '0;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_storeunit.sv
// Randomized and directed bench for storeunit with a byte-lane reference model.
// Expectations for swl/swr follow STORE_UNALIGNED_EN.
module tb_storeunit;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SWR = 6'b101110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] storedata = '0;
    logic        busy, done, fault, mem_write;
    logic [31:0] mem_address, mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b0;

    int passed = 0;
    int total = 0;

    bit          obs_done, obs_fault, obs_wr, obs_stable, obs_tail;
    int          obs_lat, obs_busy;
    logic [31:0] obs_addr, obs_data;
    logic [3:0]  obs_be;

    storeunit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .addr(addr), .storedata(storedata), .busy(busy), .done(done),
        .fault(fault), .mem_address(mem_address), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    // Byte-lane view: which source byte of rt lands in each enabled lane.
    function automatic void model(input logic [5:0] op, input logic [31:0] a,
                                  input logic [31:0] d, output bit flt,
                                  output logic [3:0] ebe, output logic [31:0] edata);
        int off;
        bit en;
        int src;
        off = int'(a[1:0]);
        flt = 1'b0;
        ebe = '0;
        edata = '0;
        for (int n = 0; n < 4; n++) begin
            en = 1'b0;
            src = 0;
            if (op == OP_SB) begin
                en = (n == off);
                src = 0;
            end else if (op == OP_SH) begin
                if (off % 2 != 0) flt = 1'b1;
                en = (n == off) || (n == off + 1);
                src = n - off;
            end else if (op == OP_SW) begin
                if (off != 0) flt = 1'b1;
                en = 1'b1;
                src = n;
`ifdef STORE_UNALIGNED_EN
            end else if (op == OP_SWL) begin
                en = (n <= off);
                src = 3 - off + n;
            end else if (op == OP_SWR) begin
                en = (n >= off);
                src = n - off;
`endif
            end else begin
                flt = 1'b1;
            end
            if (en) begin
                ebe[n] = 1'b1;
                edata[8*n +: 8] = d[8*src +: 8];
            end
        end
        if (flt) begin
            ebe = '0;
            edata = '0;
        end
    endfunction

    // Drives one request and records what the bus and status lines did.
    task automatic run_store(input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] d, input int stalls);
        int wcnt;
        obs_done = 0; obs_fault = 0; obs_wr = 0; obs_stable = 1;
        obs_lat = 0; obs_busy = 0; obs_tail = 0;
        obs_addr = '0; obs_be = '0; obs_data = '0;
        wcnt = 0;
        opcode = op; addr = a; storedata = d; start = 1'b1;
        mem_waitrequest = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        opcode = 6'($urandom); addr = $urandom; storedata = $urandom;
        for (int n = 1; n <= 60; n++) begin
            if (busy) obs_busy++;
            if (busy !== mem_write) obs_stable = 0;
            if (mem_write) begin
                if (!obs_wr) begin
                    obs_addr = mem_address;
                    obs_be = mem_byteenable;
                    obs_data = mem_writedata;
                end else if (mem_address !== obs_addr || mem_byteenable !== obs_be ||
                             mem_writedata !== obs_data) begin
                    obs_stable = 0;
                end
                obs_wr = 1;
                wcnt++;
                mem_waitrequest = (wcnt <= stalls);
            end else begin
                mem_waitrequest = 1'($urandom_range(0, 1));
            end
            if (done === 1'b1 || fault === 1'b1) begin
                obs_done = (done === 1'b1);
                obs_fault = (fault === 1'b1);
                obs_lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        obs_tail = done | fault | busy | mem_write;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, fault, mem_write} !== 4'b0) begin
            $display("FAIL reset_ctrl got %b want 0000", {busy, done, fault, mem_write});
        end else passed++;
        total++;
        if ({mem_address, mem_byteenable, mem_writedata} !== 68'b0) begin
            $display("FAIL reset_bus got %h %b %h want 0", mem_address, mem_byteenable,
                     mem_writedata);
        end else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sb();
        run_store(OP_SB, 32'h0000_1003, 32'hAABB_CCDD, 0);
        total++;
        if (!obs_done || obs_lat != 2) begin
            $display("FAIL sb_latency got done=%0d lat=%0d want done=1 lat=2", obs_done, obs_lat);
        end else passed++;
        total++;
        if (obs_addr !== 32'h1000 || obs_be !== 4'b1000 || obs_data !== 32'hDD00_0000) begin
            $display("FAIL sb_bus got %h %b %h want 00001000 1000 dd000000", obs_addr,
                     obs_be, obs_data);
        end else passed++;
    endtask

    task automatic test_sh_stall();
        run_store(OP_SH, 32'h0000_2002, 32'h1234_5678, 3);
        total++;
        if (obs_be !== 4'b1100 || obs_data !== 32'h5678_0000 || !obs_stable) begin
            $display("FAIL sh_bus got %b %h stable=%0d want 1100 56780000 stable=1", obs_be,
                     obs_data, obs_stable);
        end else passed++;
        total++;
        if (!obs_done || obs_lat != 5 || obs_busy != 4) begin
            $display("FAIL sh_stall_timing got lat=%0d busy=%0d want lat=5 busy=4", obs_lat,
                     obs_busy);
        end else passed++;
    endtask

    task automatic test_sw_fault();
        run_store(OP_SW, 32'h0000_3001, 32'hCAFE_F00D, 0);
        total++;
        if (!obs_fault || obs_lat != 1 || obs_wr || obs_busy != 0 || obs_tail) begin
            $display("FAIL sw_fault got f=%0d lat=%0d wr=%0d busy=%0d tail=%0d want 1 1 0 0 0",
                     obs_fault, obs_lat, obs_wr, obs_busy, obs_tail);
        end else passed++;
    endtask

    task automatic test_unaligned();
        run_store(OP_SWL, 32'h0000_4001, 32'h1122_3344, 0);
        total++;
`ifdef STORE_UNALIGNED_EN
        if (!obs_done || obs_be !== 4'b0011 || obs_data !== 32'h0000_1122) begin
            $display("FAIL swl got done=%0d %b %h want 1 0011 00001122", obs_done, obs_be,
                     obs_data);
        end else passed++;
`else
        if (!obs_fault || obs_wr) begin
            $display("FAIL swl got fault=%0d wr=%0d want 1 0", obs_fault, obs_wr);
        end else passed++;
`endif
        run_store(OP_SWR, 32'h0000_4001, 32'h1122_3344, 1);
        total++;
`ifdef STORE_UNALIGNED_EN
        if (!obs_done || obs_be !== 4'b1110 || obs_data !== 32'h2233_4400) begin
            $display("FAIL swr got done=%0d %b %h want 1 1110 22334400", obs_done, obs_be,
                     obs_data);
        end else passed++;
`else
        if (!obs_fault || obs_wr) begin
            $display("FAIL swr got fault=%0d wr=%0d want 1 0", obs_fault, obs_wr);
        end else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        opcode = OP_SW; addr = 32'h10; storedata = 32'h1; start = 1'b1;
        mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1) begin
            $display("FAIL b2b_done got %b want 1", done);
        end else passed++;
        opcode = OP_SB; addr = 32'h20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_write !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL b2b_ignore_in_done got wr=%b busy=%b want 0 0", mem_write, busy);
        end else passed++;
        run_store(OP_SB, 32'h0000_0021, 32'h0000_00A5, 0);
        run_store(OP_SH, 32'h0000_0030, 32'h0000_BEEF, 0);
        total++;
        if (!obs_done || obs_lat != 2 || obs_data !== 32'h0000_BEEF) begin
            $display("FAIL b2b_next got done=%0d lat=%0d %h want 1 2 0000beef", obs_done,
                     obs_lat, obs_data);
        end else passed++;
    endtask

    task automatic test_reset_mid_write();
        opcode = OP_SH; addr = 32'h0000_2000; storedata = 32'hFFFF_1234; start = 1'b1;
        mem_waitrequest = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_write !== 1'b1) begin
            $display("FAIL midreset_pre got wr=%b want 1", mem_write);
        end else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_write, busy, mem_address, mem_byteenable, mem_writedata} !== 70'b0) begin
            $display("FAIL midreset_async got wr=%b %h %b %h want 0", mem_write, mem_address,
                     mem_byteenable, mem_writedata);
        end else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || mem_write !== 1'b0) begin
            $display("FAIL midreset_nodone got done=%b wr=%b want 0 0", done, mem_write);
        end else passed++;
        run_store(OP_SW, 32'h0000_5000, 32'h0BAD_BEEF, 0);
        total++;
        if (!obs_done || obs_addr !== 32'h5000 || obs_be !== 4'b1111 ||
            obs_data !== 32'h0BAD_BEEF) begin
            $display("FAIL midreset_recover got done=%0d %h %b %h want 1 00005000 1111 0badbeef",
                     obs_done, obs_addr, obs_be, obs_data);
        end else passed++;
    endtask

    task automatic test_random();
        logic [5:0]  ops [6];
        logic [5:0]  op;
        logic [31:0] a, d, edata;
        logic [3:0]  ebe;
        bit          flt;
        int          st;
        ops = '{OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, 6'b000000};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 5)];
            if (op == 6'b000000) op = 6'($urandom);
            a = $urandom;
            d = $urandom;
            st = $urandom_range(0, 3);
            model(op, a, d, flt, ebe, edata);
            run_store(op, a, d, st);
            total++;
            if (flt) begin
                if (!obs_fault || obs_done || obs_wr || obs_lat != 1 || obs_tail) begin
                    $display("FAIL rand_fault op=%b a=%h got f=%0d wr=%0d lat=%0d want 1 0 1",
                             op, a, obs_fault, obs_wr, obs_lat);
                end else passed++;
            end else begin
                if (!obs_done || obs_fault || obs_lat != 2 + st || obs_busy != 1 + st ||
                    !obs_stable || obs_tail || obs_addr !== {a[31:2], 2'b00} ||
                    obs_be !== ebe || obs_data !== edata) begin
                    $display("FAIL rand_store op=%b a=%h d=%h got lat=%0d %h %b %h want %0d %h %b %h",
                             op, a, d, obs_lat, obs_addr, obs_be, obs_data, 2 + st,
                             {a[31:2], 2'b00}, ebe, edata);
                end else passed++;
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sb();
        test_sh_stall();
        test_sw_fault();
        test_unaligned();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/storeunit.md
# storeunit

Store-side data-path and bus master for partial and unaligned stores (sb, sh, sw, swl, swr). It maps a register value onto byte lanes of a 32-bit little-endian data bus and generates byte enables. It then performs a single write transaction with a wait-request handshake and reports completion or an alignment fault to the CPU control FSM. It sits between the ALU effective-address output and the data memory port, mirroring the partial-load lane extraction done on the register-write side.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  store request strobe; sampled only in IDLE
- opcode  in  6  101000 sb, 101001 sh, 101011 sw, 101010 swl, 101110 swr
- addr  in  32  effective byte address (base + sign-extended offset)
- storedata  in  32  rt register value
- busy  out  1  high while a transaction is in WRITE
- done  out  1  one-cycle pulse: store committed
- fault  out  1  one-cycle pulse: misaligned or unsupported store, no bus write issued
- mem_address  out  32  word address {addr[31:2], 2'b00}
- mem_write  out  1  write strobe
- mem_byteenable  out  4  lane enables, bit n = bits [8n+7:8n]
- mem_writedata  out  32  lane-aligned data; disabled lanes driven 0
- mem_waitrequest  in  1  slave stall; write completes on a cycle with mem_write=1 and mem_waitrequest=0

## Operation
- Clock is clk; reset is rst_n, asynchronous, active-low.
- States: IDLE, WRITE, DONE, FAULT.
- IDLE + start: capture opcode, addr, storedata; compute lanes from off = addr[1:0].
  - Valid store -> WRITE.
  - Misaligned or unsupported store -> FAULT.
- Lane mapping, d = storedata:
  - sb: BE = 1<<off; data = d[7:0] << 8*off.
  - sh: requires off[0]=0.
    - off 0: BE 0011, data {16'0, d[15:0]}.
    - off 2: BE 1100, data {d[15:0], 16'0}.
  - sw: requires off=0; BE 1111, data d.
  - swl:
    - off 0: BE 0001, data[7:0]=d[31:24].
    - off 1: BE 0011, data[15:0]=d[31:16].
    - off 2: BE 0111, data[23:0]=d[31:8].
    - off 3: BE 1111, data=d.
  - swr:
    - off 0: BE 1111, data=d.
    - off 1: BE 1110, data[31:8]=d[23:0].
    - off 2: BE 1100, data[31:16]=d[15:0].
    - off 3: BE 1000, data[31:24]=d[7:0].
- Misaligned: sh with off[0]=1; sw with off!=0. Any other opcode is unsupported.
- WRITE:
  - mem_write=1; address, BE and data held stable from registers.
  - Stays in WRITE while mem_waitrequest=1.
  - Moves to DONE on the first edge with mem_waitrequest=0.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: fault=1 for one cycle, then IDLE.
- start is ignored outside IDLE, including in DONE and FAULT; the request is not queued.

## Timing
- Reset values: state IDLE; busy, done, fault, mem_write = 0; mem_address, mem_byteenable, mem_writedata = 0.
- All outputs are registered or decoded from state. No combinational path from start or mem_waitrequest to any output.
- Start accepted at edge 0:
  - mem_write high from edge 0 to edge 1.
  - With no stall, done high from edge 1 to edge 2.
  - Minimum start-to-done latency is 2 cycles; each stall cycle adds 1.
- Fault: fault high the cycle after start; mem_write never asserts.
- Back-to-back: the earliest next accepted start is in the cycle after done or fault, once the state is back in IDLE.
- Reset mid-WRITE: mem_write drops asynchronously. The transaction is abandoned with no done. Bus outputs return to 0.
- mem_waitrequest is ignored outside WRITE.

## Configuration
- Macro: STORE_UNALIGNED_EN.
- Defined: swl/swr are decoded per the lane mapping above.
- Undefined: swl/swr are treated as unsupported: FAULT, with no bus write. The swl/swr lane logic is not synthesised.

## Test plan
- sb, addr 0x1003, d 0xAABBCCDD, no stall -> mem_address 0x1000, BE 1000, data 0xDD000000, done 2 cycles after start.
- sh, addr 0x2002, d 0x12345678, waitrequest high 3 cycles -> BE 1100, data 0x56780000 held stable for 4 cycles; done 5 cycles after start.
- sw, addr 0x3001 -> fault pulse 1 cycle after start; mem_write stays 0; busy stays 0.
- With STORE_UNALIGNED_EN:
  - swl, addr 0x4001, d 0x11223344 -> BE 0011, data 0x00001122.
  - swr, same addr and d -> BE 1110, data 0x22334400.
  - Without the macro, both cause fault.
- rst_n low during a stalled WRITE -> mem_write 0 immediately, no done. A sw to 0x5000 issued after reset release completes normally.
